// File: rtl/snake_pkg.sv
// Shared types for the snake game: movement direction plus the multi-player
// link frame format (two-byte header/payload frames over a byte stream).
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } direction;

  typedef enum logic [1:0] {
    LINK_DIR    = 2'd0,
    LINK_SEED_X = 2'd1,
    LINK_SEED_Y = 2'd2,
    LINK_START  = 2'd3
  } link_type_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_PAY  = 2'd2
  } link_tx_state_e;

  typedef enum logic {
    RX_WAIT_HDR = 1'b0,
    RX_WAIT_PAY = 1'b1
  } link_rx_state_e;

  localparam logic [3:0] LINK_HDR_MAGIC = 4'hA;

  // Header byte: magic nibble, reserved zero bit, 3-bit sender id.
  function automatic logic [7:0] link_pack_hdr(input logic [2:0] id);
    return {LINK_HDR_MAGIC, 1'b0, id};
  endfunction

  // Payload byte: frame type in the top two bits, six data bits below.
  function automatic logic [7:0] link_pack_pay(input link_type_e t, input logic [5:0] data);
    return {t, data};
  endfunction

endpackage

// File: rtl/multi_link_ctrl_rx.sv
// Receive-side frame parser: pairs header and payload bytes and filters out
// frames from unknown ids or echoes of our own id. The decoded strobe is
// combinational so the parent can register its results on the payload edge.
module link_rx_parser
  import snake_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int LOCAL_ID    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       frm_valid,
  output logic [2:0] frm_id,
  output link_type_e frm_type,
  output logic [5:0] frm_data
);

  link_rx_state_e state_r, state_nx;
  logic [2:0]     hdr_id_r, hdr_id_nx;
  logic           id_ok_s;

  // Accept only peers that exist on this link and are not ourselves.
  always_comb begin
    id_ok_s = (int'(hdr_id_r) < NUM_PLAYERS) && (int'(hdr_id_r) != LOCAL_ID);
  end

  // Next-state and decoded-frame strobe.
  always_comb begin
    state_nx  = state_r;
    hdr_id_nx = hdr_id_r;
    frm_valid = 1'b0;
    frm_id    = hdr_id_r;
    frm_type  = link_type_e'(rx_data[7:6]);
    frm_data  = rx_data[5:0];
    case (state_r)
      RX_WAIT_HDR: begin
        if (rx_valid && (rx_data[7:4] == LINK_HDR_MAGIC)) begin
          state_nx  = RX_WAIT_PAY;
          hdr_id_nx = rx_data[2:0];
        end else begin
          state_nx  = RX_WAIT_HDR;
        end
      end
      RX_WAIT_PAY: begin
        if (rx_valid) begin
          state_nx  = RX_WAIT_HDR;
          frm_valid = id_ok_s;
        end else begin
          state_nx  = RX_WAIT_PAY;
        end
      end
      default: begin
        state_nx = RX_WAIT_HDR;
      end
    endcase
  end

  // State and latched header id.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RX_WAIT_HDR;
      hdr_id_r <= 3'd0;
    end else begin
      state_r  <= state_nx;
      hdr_id_r <= hdr_id_nx;
    end
  end

endmodule

// File: rtl/multi_link_ctrl.sv
// Multi-player link controller: sends the local direction each tick plus
// start/seed broadcasts, gathers peer directions into rounds, relays start
// and seed frames, and flags a sticky error when peers fall silent.
module multi_link_ctrl
  import snake_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int LOCAL_ID      = 0,
  parameter int TIMEOUT_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     enable,
  input  logic [1:0]               dir_local,
  input  logic                     start_req,
  input  logic                     seed_rdy,
  input  logic [5:0]               seed_x_in,
  input  logic [5:0]               seed_y_in,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [NUM_PLAYERS*2-1:0] dirs_out,
  output logic                     rcvdir,
  output logic                     start_game,
  output logic [5:0]               seed_x_out,
  output logic [5:0]               seed_y_out,
  output logic                     seed_valid,
  output logic                     con_error
);

  localparam logic [7:0] ALL_MASK  = 8'hFF >> (8 - NUM_PLAYERS);
  localparam logic [7:0] PEER_MASK = ALL_MASK & ~(8'd1 << LOCAL_ID);
  localparam logic [2:0] LOCAL_ID3 = 3'(LOCAL_ID);
  localparam logic [3:0] TIMEOUT4  = 4'(TIMEOUT_TICKS);

  // ---------------- transmit side ----------------
  link_tx_state_e tx_state_r, tx_state_nx;
  link_type_e     tx_sel_r, tx_sel_nx, pick_s;
  logic [7:0]     tx_data_r, tx_data_nx;
  logic           tx_valid_r, tx_valid_nx, tx_done_s;
  logic           start_pend_r, seedx_pend_r, seedy_pend_r, dir_pend_r;
  direction       dir_data_r;
  logic [5:0]     seed_x_tx_r, seed_y_tx_r, pay_data_s;

  // Fixed priority among pending frames: start, seed x, seed y, direction.
  always_comb begin
    if (start_pend_r) begin
      pick_s = LINK_START;
    end else if (seedx_pend_r) begin
      pick_s = LINK_SEED_X;
    end else if (seedy_pend_r) begin
      pick_s = LINK_SEED_Y;
    end else begin
      pick_s = LINK_DIR;
    end
  end

  // Payload data bits for the frame currently being served.
  always_comb begin
    case (tx_sel_r)
      LINK_DIR:    pay_data_s = {4'd0, dir_data_r};
      LINK_SEED_X: pay_data_s = seed_x_tx_r;
      LINK_SEED_Y: pay_data_s = seed_y_tx_r;
      LINK_START:  pay_data_s = 6'd0;
      default:     pay_data_s = 6'd0;
    endcase
  end

  // TX FSM next state; byte and valid are computed here and registered below.
  always_comb begin
    tx_state_nx = tx_state_r;
    tx_sel_nx   = tx_sel_r;
    tx_data_nx  = tx_data_r;
    tx_valid_nx = tx_valid_r;
    tx_done_s   = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (start_pend_r || seedx_pend_r || seedy_pend_r || dir_pend_r) begin
          tx_state_nx = TX_HDR;
          tx_sel_nx   = pick_s;
          tx_data_nx  = link_pack_hdr(LOCAL_ID3);
          tx_valid_nx = 1'b1;
        end else begin
          tx_valid_nx = 1'b0;
        end
      end
      TX_HDR: begin
        if (tx_ready) begin
          tx_state_nx = TX_PAY;
          tx_data_nx  = link_pack_pay(tx_sel_r, pay_data_s);
          tx_valid_nx = 1'b1;
        end else begin
          tx_state_nx = TX_HDR;
        end
      end
      TX_PAY: begin
        if (tx_ready) begin
          tx_state_nx = TX_IDLE;
          tx_valid_nx = 1'b0;
          tx_done_s   = 1'b1;
        end else begin
          tx_state_nx = TX_PAY;
        end
      end
      default: begin
        tx_state_nx = TX_IDLE;
        tx_valid_nx = 1'b0;
      end
    endcase
  end

  // TX state and registered byte outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
      tx_sel_r   <= LINK_DIR;
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
    end else begin
      tx_state_r <= tx_state_nx;
      tx_sel_r   <= tx_sel_nx;
      tx_data_r  <= tx_data_nx;
      tx_valid_r <= tx_valid_nx;
    end
  end

  // Pending-frame flags: new requests win over the clear of a served frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_pend_r <= 1'b0;
      seedx_pend_r <= 1'b0;
      seedy_pend_r <= 1'b0;
      dir_pend_r   <= 1'b0;
      dir_data_r   <= DIR_UP;
      seed_x_tx_r  <= 6'd0;
      seed_y_tx_r  <= 6'd0;
    end else begin
      if (start_req) begin
        start_pend_r <= 1'b1;
      end else if (tx_done_s && (tx_sel_r == LINK_START)) begin
        start_pend_r <= 1'b0;
      end
      if (seed_rdy) begin
        seedx_pend_r <= 1'b1;
        seedy_pend_r <= 1'b1;
        seed_x_tx_r  <= seed_x_in;
        seed_y_tx_r  <= seed_y_in;
      end else begin
        if (tx_done_s && (tx_sel_r == LINK_SEED_X)) seedx_pend_r <= 1'b0;
        if (tx_done_s && (tx_sel_r == LINK_SEED_Y)) seedy_pend_r <= 1'b0;
      end
      if (enable && tick) begin
        dir_pend_r <= 1'b1;
        dir_data_r <= direction'(dir_local);
      end else if (tx_done_s && (tx_sel_r == LINK_DIR)) begin
        dir_pend_r <= 1'b0;
      end
    end
  end

  // ---------------- receive side ----------------
  logic                     frm_valid_s;
  logic [2:0]               frm_id_s;
  link_type_e               frm_type_s;
  logic [5:0]               frm_data_s;
  logic [7:0]               got_r, got_nx;
  logic                     dir_rx_s, round_done_s, timeout_s;
  logic [3:0]               tick_cnt_r;
  logic [NUM_PLAYERS*2-1:0] dirs_r;
  logic                     rcvdir_r, start_game_r, seed_valid_r, con_error_r;
  logic [5:0]               seed_x_out_r, seed_y_out_r, seedx_store_r;
  logic                     seedx_have_r;

  link_rx_parser #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .LOCAL_ID    (LOCAL_ID)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frm_valid (frm_valid_s),
    .frm_id    (frm_id_s),
    .frm_type  (frm_type_s),
    .frm_data  (frm_data_s)
  );

  // Round tracking and timeout decision; completion masks a same-cycle timeout.
  always_comb begin
    dir_rx_s = frm_valid_s && (frm_type_s == LINK_DIR);
    if (dir_rx_s) begin
      got_nx = got_r | (8'd1 << frm_id_s);
    end else begin
      got_nx = got_r;
    end
    round_done_s = dir_rx_s && ((got_nx & PEER_MASK) == PEER_MASK);
    timeout_s    = enable && tick && !round_done_s && ((tick_cnt_r + 4'd1) >= TIMEOUT4);
  end

  // Received-frame bookkeeping, pulse outputs and the sticky link error.
  always_ff @(posedge clk) begin
    if (rst) begin
      got_r         <= 8'd0;
      tick_cnt_r    <= 4'd0;
      dirs_r        <= '0;
      rcvdir_r      <= 1'b0;
      start_game_r  <= 1'b0;
      seed_valid_r  <= 1'b0;
      seed_x_out_r  <= 6'd0;
      seed_y_out_r  <= 6'd0;
      seedx_store_r <= 6'd0;
      seedx_have_r  <= 1'b0;
      con_error_r   <= 1'b0;
    end else begin
      rcvdir_r     <= round_done_s;
      start_game_r <= frm_valid_s && (frm_type_s == LINK_START);
      seed_valid_r <= 1'b0;
      got_r        <= round_done_s ? 8'd0 : got_nx;
      if (dir_rx_s) dirs_r[2*int'(frm_id_s) +: 2] <= frm_data_s[1:0];
      if (enable && tick) dirs_r[2*LOCAL_ID +: 2] <= dir_local;
      if (frm_valid_s && (frm_type_s == LINK_SEED_X)) begin
        seedx_store_r <= frm_data_s;
        seedx_have_r  <= 1'b1;
      end else if (frm_valid_s && (frm_type_s == LINK_SEED_Y) && seedx_have_r) begin
        seed_x_out_r <= seedx_store_r;
        seed_y_out_r <= frm_data_s;
        seed_valid_r <= 1'b1;
        seedx_have_r <= 1'b0;
      end
      if (!enable || round_done_s) begin
        tick_cnt_r <= 4'd0;
      end else if (tick && (tick_cnt_r != 4'd15)) begin
        tick_cnt_r <= tick_cnt_r + 4'd1;
      end
      if (timeout_s) con_error_r <= 1'b1;
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign dirs_out   = dirs_r;
  assign rcvdir     = rcvdir_r;
  assign start_game = start_game_r;
  assign seed_x_out = seed_x_out_r;
  assign seed_y_out = seed_y_out_r;
  assign seed_valid = seed_valid_r;
  assign con_error  = con_error_r;

endmodule

// File: tb/tb_multi_link_ctrl.sv
// Directed bench: a 2-player instance (timeout 4) and a 4-player instance
// (timeout 2) share all inputs; each scenario targets one of them.
module tb_multi_link_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, enable = 1'b0, start_req = 1'b0, seed_rdy = 1'b0;
  logic [1:0] dir_local = 2'd0;
  logic [5:0] seed_x_in = 6'd0, seed_y_in = 6'd0;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;

  logic [7:0] tx_data2, tx_data4;
  logic       tx_valid2, tx_valid4;
  logic [3:0] dirs2;
  logic [7:0] dirs4;
  logic       rcvdir2, rcvdir4, sg2, sg4, sv2, sv4, ce2, ce4;
  logic [5:0] sx2, sy2, sx4, sy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_link_ctrl #(.NUM_PLAYERS(2), .LOCAL_ID(0), .TIMEOUT_TICKS(4)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .dir_local(dir_local),
    .start_req(start_req), .seed_rdy(seed_rdy), .seed_x_in(seed_x_in), .seed_y_in(seed_y_in),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .dirs_out(dirs2), .rcvdir(rcvdir2),
    .start_game(sg2), .seed_x_out(sx2), .seed_y_out(sy2), .seed_valid(sv2), .con_error(ce2));

  multi_link_ctrl #(.NUM_PLAYERS(4), .LOCAL_ID(0), .TIMEOUT_TICKS(2)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .dir_local(dir_local),
    .start_req(start_req), .seed_rdy(seed_rdy), .seed_x_in(seed_x_in), .seed_y_in(seed_y_in),
    .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .dirs_out(dirs4), .rcvdir(rcvdir4),
    .start_game(sg4), .seed_x_out(sx4), .seed_y_out(sy4), .seed_valid(sv4), .con_error(ce4));

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] pay;
    logic [7:0] dirs;
    logic       rcv;
    logic       sg;
    logic       sv;
    logic [5:0] sx;
    logic [5:0] sy;
  } rx_vec_t;

  rx_vec_t vec [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Waits (bounded) for a TX byte on the 2-player instance and accepts it.
  task automatic get_byte(output logic [7:0] b);
    int k = 0;
    while (!tx_valid2 && k < 20) begin
      cyc();
      k++;
    end
    if (!tx_valid2) begin
      checks++;
      errors++;
      $display("FAIL tx_wait actual=no_valid expected=valid");
      b = 8'h00;
    end else begin
      b = tx_data2;
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp_tx [8];
    logic       stable;

    // hdr, pay, dirs4, rcvdir4, start_game4, seed_valid4, seed_x_out4, seed_y_out4
    vec[0]  = '{8'hA1, 8'h02, 8'h08, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[1]  = '{8'hA3, 8'h01, 8'h48, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[2]  = '{8'hA1, 8'h03, 8'h4C, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[3]  = '{8'hA2, 8'h02, 8'h6C, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[4]  = '{8'hA2, 8'h01, 8'h5C, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[5]  = '{8'h55, 8'h55, 8'h5C, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[6]  = '{8'hA0, 8'h03, 8'h5C, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[7]  = '{8'hA4, 8'h01, 8'h5C, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[8]  = '{8'hA2, 8'h8A, 8'h5C, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[9]  = '{8'hA1, 8'h45, 8'h5C, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0};
    vec[10] = '{8'hA3, 8'h89, 8'h5C, 1'b0, 1'b0, 1'b1, 6'd5, 6'd9};
    vec[11] = '{8'hA1, 8'hC0, 8'h5C, 1'b0, 1'b1, 1'b0, 6'd5, 6'd9};
    vec[12] = '{8'hA3, 8'h00, 8'h1C, 1'b0, 1'b0, 1'b0, 6'd5, 6'd9};
    vec[13] = '{8'hA1, 8'h02, 8'h18, 1'b1, 1'b0, 1'b0, 6'd5, 6'd9};

    exp_tx[0] = 8'hA0; exp_tx[1] = 8'hC0; exp_tx[2] = 8'hA0; exp_tx[3] = 8'h45;
    exp_tx[4] = 8'hA0; exp_tx[5] = 8'h89; exp_tx[6] = 8'hA0; exp_tx[7] = 8'h02;

    // Reset state
    do_reset();
    check("rst_tx_valid", 32'(tx_valid2), 32'd0);
    check("rst_tx_data", 32'(tx_data2), 32'd0);
    check("rst_dirs4", 32'(dirs4), 32'd0);
    check("rst_pulses4", {29'd0, rcvdir4, sg4, sv4}, 32'd0);
    check("rst_con_error4", 32'(ce4), 32'd0);
    check("rst_seed4", {20'd0, sx4, sy4}, 32'd0);

    // Table-driven RX frames into the 4-player instance
    for (int i = 0; i < 14; i++) begin
      send(vec[i].hdr);
      send(vec[i].pay);
      check($sformatf("v%0d_dirs", i), 32'(dirs4), 32'(vec[i].dirs));
      check($sformatf("v%0d_rcvdir", i), 32'(rcvdir4), 32'(vec[i].rcv));
      check($sformatf("v%0d_start", i), 32'(sg4), 32'(vec[i].sg));
      check($sformatf("v%0d_seedv", i), 32'(sv4), 32'(vec[i].sv));
      check($sformatf("v%0d_seedxy", i), {20'd0, sx4, sy4}, {20'd0, vec[i].sx, vec[i].sy});
      cyc();
      check($sformatf("v%0d_pulse_end", i), {29'd0, rcvdir4, sg4, sv4}, 32'd0);
    end

    // Two players: local dir frame out, peer dir in, round pulse
    do_reset();
    enable = 1'b1;
    dir_local = 2'b01;
    pulse_tick();
    enable = 1'b0;
    check("local_dir2", 32'(dirs2), 32'h1);
    get_byte(b);
    check("dir_hdr", 32'(b), 32'hA0);
    get_byte(b);
    check("dir_pay", 32'(b), 32'h01);
    send(8'hA1);
    send(8'h03);
    check("peer_dir2", 32'(dirs2), 32'hD);
    check("rcvdir2_pulse", 32'(rcvdir2), 32'd1);
    cyc();
    check("rcvdir2_once", 32'(rcvdir2), 32'd0);

    // Simultaneous tick, seed and start: priority order, stall with tx_ready low
    do_reset();
    enable = 1'b1; tick = 1'b1; dir_local = 2'b10;
    seed_rdy = 1'b1; start_req = 1'b1; seed_x_in = 6'd5; seed_y_in = 6'd9;
    cyc();
    enable = 1'b0; tick = 1'b0; seed_rdy = 1'b0; start_req = 1'b0;
    for (int k = 0; k < 20 && !tx_valid2; k++) cyc();
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (!(tx_valid2 && (tx_data2 == 8'hA0))) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    for (int i = 0; i < 8; i++) begin
      get_byte(b);
      check($sformatf("tx_seq%0d", i), 32'(b), 32'(exp_tx[i]));
    end
    cyc(); cyc(); cyc();
    check("tx_no_extra", 32'(tx_valid2), 32'd0);

    // Timeout on the 4-player instance (2 ticks), sticky until reset
    do_reset();
    enable = 1'b1;
    pulse_tick();
    cyc(); cyc();
    check("to_after1", 32'(ce4), 32'd0);
    pulse_tick();
    check("to_set", 32'(ce4), 32'd1);
    check("to_not2", 32'(ce2), 32'd0);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    check("to_sticky", 32'(ce4), 32'd1);
    do_reset();
    check("to_rst_clear", 32'(ce4), 32'd0);

    // enable low zeroes the tick counter
    enable = 1'b1;
    pulse_tick();
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    pulse_tick();
    check("en_hold", 32'(ce4), 32'd0);
    enable = 1'b0;

    // Round completion in the same cycle as a timeout tick wins
    do_reset();
    enable = 1'b1;
    pulse_tick();
    send(8'hA1); send(8'h00);
    send(8'hA2); send(8'h00);
    send(8'hA3);
    rx_data = 8'h00; rx_valid = 1'b1; tick = 1'b1;
    cyc();
    rx_valid = 1'b0; tick = 1'b0;
    check("win_rcvdir4", 32'(rcvdir4), 32'd1);
    check("win_no_err", 32'(ce4), 32'd0);
    pulse_tick();
    check("win_cnt_zeroed", 32'(ce4), 32'd0);
    enable = 1'b0;

    // Reset mid-frame abandons the partial frame
    do_reset();
    send(8'hA1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    send(8'h03);
    check("midrst_rcvdir2", 32'(rcvdir2), 32'd0);
    check("midrst_dirs2", 32'(dirs2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
